// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding,
// one-hot grant constants and the round-robin pick.
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StToerr = 2'd2
  } arb_state_e;

  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntM0   = 2'b01;
  localparam logic [1:0] GntM1   = 2'b10;

  // On a tie the master that did not own the bus last time wins.
  function automatic logic [1:0] rr_pick(input logic req0, input logic req1,
                                         input logic [1:0] last);
    if (req0 && req1) begin
      return (last == GntM0) ? GntM1 : GntM0;
    end else if (req0) begin
      return GntM0;
    end else if (req1) begin
      return GntM1;
    end
    return GntNone;
  endfunction

endpackage

// File: rtl/wb_outstanding_tracker.sv
// Counts issued-but-unanswered slave transactions and flags a response
// timeout when requests sit outstanding with no ack/err for too long.
module wb_outstanding_tracker
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned OUTST_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               issue,
  input  logic               rsp,
  output logic [OUTST_W-1:0] count,
  output logic               full,
  output logic               timeout
);

  localparam logic [OUTST_W-1:0] CountMax = '1;
  // The error cycle itself is the last silent cycle, so fire one early.
  localparam logic [7:0] IdleLimit = 8'(TIMEOUT_CYCLES - 2);

  logic [OUTST_W-1:0] count_q;
  logic [7:0]         idle_q;
  logic               running;

  assign running = (count_q != '0) && !issue && !rsp;
  assign count   = count_q;
  assign full    = (count_q == CountMax);
  assign timeout = running && (idle_q == IdleLimit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
      idle_q  <= '0;
    end else begin
      if (issue && !rsp) begin
        count_q <= count_q + 1'b1;
      end else if (rsp && !issue) begin
        count_q <= count_q - 1'b1;
      end
      idle_q <= running ? idle_q + 8'd1 : 8'd0;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone pipelined arbiter with outstanding
// transaction limiting and a response-timeout bus error.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned OUTST_W        = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  output logic        m0_wb_stall_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  output logic [31:0] m0_wb_dat_o,

  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  output logic        m1_wb_stall_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] m1_wb_dat_o,

  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  input  logic        s_wb_stall_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  input  logic [31:0] s_wb_dat_i,

  output logic [1:0]  grant_o
);

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic [1:0] last_q;
  logic [1:0] pick;

  logic        active;
  logic        toerr_pulse;
  logic        o_cyc, o_stb, o_we;
  logic [31:0] o_adr, o_wdat;
  logic [3:0]  o_sel;
  logic        o_stall, o_ack, o_err;
  logic [31:0] o_rdat;

  logic               issue, rsp, clear, full, timeout;
  logic [OUTST_W-1:0] count;

  // Reset gates every output immediately, before the state register clears.
  assign active      = (state_q == StGrant) && !wb_rst_i;
  assign toerr_pulse = (state_q == StToerr) && !wb_rst_i;
  assign pick        = rr_pick(m0_wb_cyc_i, m1_wb_cyc_i, last_q);

  always_comb begin
    if (grant_q[1]) begin
      o_cyc  = m1_wb_cyc_i;
      o_stb  = m1_wb_stb_i;
      o_we   = m1_wb_we_i;
      o_adr  = m1_wb_adr_i;
      o_wdat = m1_wb_dat_i;
      o_sel  = m1_wb_sel_i;
    end else begin
      o_cyc  = m0_wb_cyc_i;
      o_stb  = m0_wb_stb_i;
      o_we   = m0_wb_we_i;
      o_adr  = m0_wb_adr_i;
      o_wdat = m0_wb_dat_i;
      o_sel  = m0_wb_sel_i;
    end
  end

  assign s_wb_cyc_o = active && o_cyc;
  assign s_wb_stb_o = s_wb_cyc_o && o_stb && !full;
  assign s_wb_we_o  = active && o_we;
  assign s_wb_adr_o = active ? o_adr : 32'h0;
  assign s_wb_dat_o = active ? o_wdat : 32'h0;
  assign s_wb_sel_o = active ? o_sel : 4'h0;

  assign issue = s_wb_stb_o && !s_wb_stall_i;
  // Responses with nothing in flight are strays from an abandoned cycle.
  assign rsp   = s_wb_cyc_o && (s_wb_ack_i || s_wb_err_i) && ((count != '0) || issue);
  assign clear = !s_wb_cyc_o;

  assign o_stall = !active || full || s_wb_stall_i;
  assign o_ack   = rsp && s_wb_ack_i;
  assign o_err   = (rsp && s_wb_err_i) || toerr_pulse;
  assign o_rdat  = active ? s_wb_dat_i : 32'h0;

  assign m0_wb_stall_o = grant_q[0] ? o_stall : 1'b1;
  assign m0_wb_ack_o   = grant_q[0] && o_ack;
  assign m0_wb_err_o   = grant_q[0] && o_err;
  assign m0_wb_dat_o   = grant_q[0] ? o_rdat : 32'h0;
  assign m1_wb_stall_o = grant_q[1] ? o_stall : 1'b1;
  assign m1_wb_ack_o   = grant_q[1] && o_ack;
  assign m1_wb_err_o   = grant_q[1] && o_err;
  assign m1_wb_dat_o   = grant_q[1] ? o_rdat : 32'h0;

  assign grant_o = grant_q;

  wb_outstanding_tracker #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .OUTST_W       (OUTST_W)
  ) u_tracker (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (clear),
    .issue  (issue),
    .rsp    (rsp),
    .count  (count),
    .full   (full),
    .timeout(timeout)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      grant_q <= GntNone;
      last_q  <= GntM1;
    end else begin
      case (state_q)
        StIdle: begin
          if (m0_wb_cyc_i || m1_wb_cyc_i) begin
            state_q <= StGrant;
            grant_q <= pick;
            last_q  <= pick;
          end
        end
        StGrant: begin
          if (!o_cyc) begin
            state_q <= StIdle;
            grant_q <= GntNone;
          end else if (timeout) begin
            state_q <= StToerr;
          end
        end
        StToerr: begin
          state_q <= StIdle;
          grant_q <= GntNone;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= GntNone;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of cycles with requests outstanding and no ack/err before a bus-error is forced (range 2..255).
REQ-002 SHALL have parameter OUTST_W, default 3, meaning the width of the outstanding-transaction counter (maximum 2**OUTST_W-1 in flight).
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock, all logic rising-edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i, inputs, 1 each, master 0 (instruction) cycle, strobe and write-enable.
REQ-006 SHALL have ports m0_wb_adr_i, m0_wb_dat_i, m0_wb_sel_i, inputs, 32/32/4, master 0 address, write data and byte select.
REQ-007 SHALL have ports m0_wb_stall_o, m0_wb_ack_o, m0_wb_err_o, m0_wb_dat_o, outputs, 1/1/1/32, master 0 stall, ack, error and read data.
REQ-008 SHALL have a master 1 (data) port set m1_wb_*, identical in names, directions and widths to REQ-005..007.
REQ-009 SHALL have ports s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, outputs, 1/1/1/32/32/4, the shared slave request.
REQ-010 SHALL have ports s_wb_stall_i, s_wb_ack_i, s_wb_err_i, s_wb_dat_i, inputs, 1/1/1/32, the shared slave response.
REQ-011 SHALL have port grant_o, output, 2, one-hot current owner, for debug and performance counters.

Function
REQ-012 SHALL implement a state machine with states IDLE, GRANT and TOERR.
REQ-013 In IDLE, SHALL sample m0_wb_cyc_i/m1_wb_cyc_i; on any request SHALL move to GRANT on the next edge, so grant latency is 1 cycle.
REQ-014 On simultaneous requests, SHALL grant the master not granted last (round-robin); a single requester SHALL be granted directly.
REQ-015 In GRANT, SHALL pass the owner's cyc/stb/we/adr/dat/sel to s_wb_* combinationally and route s_wb_stall/ack/err/dat to the owner.
REQ-016 The non-owner SHALL see stall_o=1, ack_o=0, err_o=0 and dat_o=0; in IDLE both masters SHALL see stall_o=1.
REQ-017 The outstanding counter SHALL increment on stb&~stall, decrement on ack|err, and hold when both occur in the same cycle.
REQ-018 An issue attempt with the counter at maximum SHALL be stalled toward the master and s_wb_stb_o SHALL be held 0.
REQ-019 When the owner drops cyc, SHALL return to IDLE on the next edge, clear the counter and timeout count, and drop s_wb_cyc_o in that same cycle; acks arriving afterwards SHALL be discarded.
REQ-020 The timeout count SHALL run only while the counter is nonzero, and SHALL clear on any ack/err or new issue.
REQ-021 When the timeout count reaches TIMEOUT_CYCLES, SHALL enter TOERR, where s_wb_cyc_o=0 and the owner's err_o=1 for exactly 1 cycle; it SHALL then clear the counter and go to IDLE.
REQ-022 SHALL register last_grant on each IDLE->GRANT transition.
REQ-023 s_wb_cyc_o SHALL be 0 outside GRANT.

Reset
REQ-024 On reset, SHALL set state=IDLE, grant_o=2'b00, counters=0 and last_grant=m1, so m0 wins the first tie.
REQ-025 During reset, all s_wb_* outputs, ack_o and err_o SHALL be 0 and stall_o SHALL be 1.
REQ-026 Reset asserted mid-transaction SHALL abort it without any ack or err to either master.

Structure
REQ-027 The state encoding and the grant one-hot constants SHALL live in the shared package wb_pkg.
REQ-028 The outstanding/timeout tracking SHALL be one sub-module, wb_outstanding_tracker, instantiated once.

Verification
REQ-029 m0 alone reads 0x0000_0100 with slave ack 1 cycle later -> grant_o=01 one cycle after cyc, m0_wb_ack_o with the slave data, m1_wb_stall_o=1 throughout.
REQ-030 m0 and m1 both raise cyc after reset -> m0 granted first; after m0 drops cyc and both re-request, m1 is granted.
REQ-031 m1 pipelines 7 writes with no stall and acks withheld -> 8th issue stalled, s_wb_stb_o=0 until the first ack.
REQ-032 m1 issues 1 read, slave never acks, TIMEOUT_CYCLES=16 -> m1_wb_err_o pulses 1 cycle at the 16th idle cycle, then IDLE with s_wb_cyc_o=0.
REQ-033 m0 drops cyc with 2 outstanding, then late slave ack -> no ack to either master; m1 pending is granted 1 cycle later.
REQ-034 wb_rst_i pulsed during a granted burst -> all outputs return to reset values on the next edge; first post-reset tie goes to m0.
